// File: rtl/phase_scan_controller.sv
// phase_scan_controller: PLL dynamic phase scan sequencer (output clock domain).
// Steps the PLL through NSTEPS phase settings. At each one it settles, counts
// det_in pulses over a dwell window, and hands out a (phase, count) result on
// a valid/ready port. After the last result it steps the PLL back around.
// Optional feature macro: PHASE_SCAN_BEST_EN tracks the best phase, parks the
// PLL there at the end of the scan, and adds the best_phase/best_count ports.
module phase_scan_controller #(
    parameter int NSTEPS  = 32,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [2:0]         veto_cfg,
    output logic [2:0]         vetoLast,
    input  logic               det_in,
    output logic               phasestep,
    output logic               phaseupdown,
    output logic [2:0]         phasecounterselect,
    input  logic               phasedone,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_phase,
    output logic [CNT_W-1:0]   res_count
`ifdef PHASE_SCAN_BEST_EN
    ,
    output logic [7:0]         best_phase,
    output logic [CNT_W-1:0]   best_count
`endif
);

    // One shared cycle timer serves settle, dwell and timeout; size it for the largest.
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int STL_W = $clog2(SETTLE + 1);
    localparam int TW0   = (DWELL_W > TMO_W) ? DWELL_W : TMO_W;
    localparam int TW    = ((TW0 > STL_W) ? TW0 : STL_W) + 1;
    localparam logic [TW-1:0] SETTLE_LAST = (SETTLE > 0) ? TW'(SETTLE - 1) : '0;
    localparam logic [TW-1:0] TMO_LIM     = TW'(TIMEOUT);
    localparam logic [7:0]    LAST_IDX    = 8'(NSTEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_COUNT, S_REPORT, S_STEP, S_WAITLO, S_WAITHI, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [2:0]         veto_q;
    logic [7:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ret_q;
    logic [7:0]         ret_q;
    logic               done_q, error_q;
    logic               timeout;
    logic [7:0]         ret_init;
    logic [TW-1:0]      dwell_last;
    logic               last_res;

    assign dwell_last = TW'(dwell_q) - TW'(1);
    assign last_res   = (idx_q == LAST_IDX);

`ifdef PHASE_SCAN_BEST_EN
    logic [7:0]       best_ph_q, best_ph_nx;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_nx;

    // Best candidate including the result currently on offer; ties keep the lower index.
    always_comb begin
        best_ph_nx  = best_ph_q;
        best_cnt_nx = best_cnt_q;
        if (idx_q == 8'd0 || cnt_q > best_cnt_q) begin
            best_ph_nx  = idx_q;
            best_cnt_nx = cnt_q;
        end
    end

    // From the last phase, best+1 steps wrap around to the best phase (0 if it is the last).
    assign ret_init   = (best_ph_nx == LAST_IDX) ? 8'd0 : best_ph_nx + 8'd1;
    assign best_phase = best_ph_q;
    assign best_count = best_cnt_q;
`else
    // One step from the last phase completes the rotation back to phase 0.
    assign ret_init = 8'd1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; phasedone arriving wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (tmr_q == SETTLE_LAST) state_d = S_COUNT;
            S_COUNT:  if (tmr_q == dwell_last) state_d = S_REPORT;
            S_REPORT: if (res_ready) state_d = (last_res && ret_init == 8'd0) ? S_FINISH : S_STEP;
            S_STEP:   state_d = S_WAITLO;
            S_WAITLO: begin
                if (!phasedone) state_d = S_WAITHI;
                else if (tmr_q == TMO_LIM) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end
            end
            S_WAITHI: begin
                if (phasedone) begin
                    if (!in_ret_q)         state_d = S_SETTLE;
                    else if (ret_q == 8'd1) state_d = S_FINISH;
                    else                   state_d = S_STEP;
                end else if (tmr_q == TMO_LIM) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; phasestep is held until phasedone drops.
    always_comb begin
        busy      = (state_q != S_IDLE);
        res_valid = (state_q == S_REPORT);
        phasestep = (state_q == S_STEP) || (state_q == S_WAITLO);
    end

    // Timer restarts on every state change and rests at zero in IDLE.
    always_comb begin
        tmr_d = tmr_q + TW'(1);
        if (state_q == S_IDLE || state_d != state_q) tmr_d = '0;
    end

    // Scan datapath: captured config, phase index, saturating counter, return steps, status.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q    <= '0;
            dwell_q  <= DWELL_W'(1);
            veto_q   <= 3'b000;
            idx_q    <= 8'd0;
            cnt_q    <= '0;
            in_ret_q <= 1'b0;
            ret_q    <= 8'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef PHASE_SCAN_BEST_EN
            best_ph_q  <= 8'd0;
            best_cnt_q <= '0;
`endif
        end else begin
            tmr_q  <= tmr_d;
            done_q <= 1'b0;
            if (state_q == S_IDLE && start) begin
                dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
                veto_q   <= veto_cfg;
                idx_q    <= 8'd0;
                cnt_q    <= '0;
                in_ret_q <= 1'b0;
                ret_q    <= 8'd0;
                error_q  <= 1'b0;
`ifdef PHASE_SCAN_BEST_EN
                best_ph_q  <= 8'd0;
                best_cnt_q <= '0;
`endif
            end
            if (state_q == S_COUNT && det_in && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == S_REPORT && res_ready) begin
                cnt_q <= '0;
`ifdef PHASE_SCAN_BEST_EN
                best_ph_q  <= best_ph_nx;
                best_cnt_q <= best_cnt_nx;
`endif
                if (last_res) begin
                    in_ret_q <= 1'b1;
                    ret_q    <= ret_init;
                end else begin
                    idx_q <= idx_q + 8'd1;
                end
            end
            if (state_q == S_WAITHI && phasedone && in_ret_q)
                ret_q <= ret_q - 8'd1;
            if (timeout) begin
                error_q <= 1'b1;
                done_q  <= 1'b1;
            end
            if (state_q == S_FINISH)
                done_q <= 1'b1;
        end
    end

    assign phaseupdown        = 1'b1;
    assign phasecounterselect = 3'b010;
    assign vetoLast           = veto_q;
    assign done               = done_q;
    assign error              = error_q;
    assign res_phase          = idx_q;
    assign res_count          = cnt_q;

endmodule
